// File: rtl/msgpass_rqst_addr_gen_if.sv
// Command/status bundle between the message-pass read controller and the
// request-address sequencer; the sequencer takes the slave side.
interface msgpass_rqst_addr_gen_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DRC_NUM    = 2,
  parameter int STAT_WIDTH = 16
);
  logic                  buffer_read_begin_i;
  logic                  buffer_read_end_i;
  logic [ADDR_WIDTH-1:0] base_addr_i;
  logic [ADDR_WIDTH-1:0] last_addr_i;
  logic [DRC_NUM-1:0]    is_drc_i;
  logic [ADDR_WIDTH-1:0] addr_o;
  logic                  rd_valid_o;
  logic                  stall_o;
  logic                  busy_o;
  logic                  done_o;
  logic [STAT_WIDTH-1:0] stall_total_o;

  modport master (
    output buffer_read_begin_i, buffer_read_end_i, base_addr_i, last_addr_i, is_drc_i,
    input  addr_o, rd_valid_o, stall_o, busy_o, done_o, stall_total_o
  );

  modport slave (
    input  buffer_read_begin_i, buffer_read_end_i, base_addr_i, last_addr_i, is_drc_i,
    output addr_o, rd_valid_o, stall_o, busy_o, done_o, stall_total_o
  );
endinterface

// File: rtl/msgpass_rqst_addr_gen.sv
// Message-pass buffer read-address sequencer: walks base..last (with wrap) and
// holds the address for extra cycles while the downstream wrapper reports conflicts.
module msgpass_rqst_addr_gen #(
  parameter int ADDR_WIDTH   = 8,
  parameter int DRC_NUM      = 2,
  parameter int STALL_CYCLES = 1,
  parameter int STAT_WIDTH   = 16
) (
  input  logic                   sys_clk,
  input  logic                   rstn,
  msgpass_rqst_addr_gen_if.slave bus
);

  localparam int MAX_STALL = DRC_NUM * STALL_CYCLES;
  localparam int CNT_W     = (MAX_STALL > 1) ? $clog2(MAX_STALL) : 1;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_STALL, S_HOLD} state_e;

  state_e                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] r_last;
  logic [CNT_W-1:0]      r_stall_cnt;
  logic [STAT_WIDTH-1:0] r_stall_total;
  logic                  r_rd_valid;
  logic                  r_stall;
  logic                  r_busy;
  logic                  r_done;

  state_e                w_nxt_state;
  logic [ADDR_WIDTH-1:0] w_nxt_addr;
  logic [ADDR_WIDTH-1:0] w_nxt_last;
  logic [CNT_W-1:0]      w_nxt_cnt;
  logic [STAT_WIDTH-1:0] w_nxt_total;
  logic                  w_done;
  logic [CNT_W-1:0]      w_stall_load;

  function automatic int popcount(input logic [DRC_NUM-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < DRC_NUM; i++) n += int'(v[i]);
    return n;
  endfunction

  // Stall counter holds N-1 so the STALL state lasts exactly N cycles.
  assign w_stall_load = CNT_W'(popcount(bus.is_drc_i) * STALL_CYCLES - 1);

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_addr  = r_addr;
    w_nxt_last  = r_last;
    w_nxt_cnt   = r_stall_cnt;
    w_nxt_total = r_stall_total;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.buffer_read_begin_i) begin
          w_nxt_state = S_READ;
          w_nxt_addr  = bus.base_addr_i;
          w_nxt_last  = bus.last_addr_i;
          w_nxt_total = '0;
        end
      end
      S_READ: begin
        if (bus.buffer_read_end_i) begin
          w_nxt_state = S_IDLE;
          w_done      = 1'b1;
        end else if (bus.is_drc_i != '0) begin
          w_nxt_state = S_STALL;
          w_nxt_cnt   = w_stall_load;
        end else if (r_addr == r_last) begin
          w_nxt_state = S_HOLD;
        end else begin
          w_nxt_addr = r_addr + 1'b1;
        end
      end
      S_STALL: begin
        if (bus.buffer_read_end_i) begin
          w_nxt_state = S_IDLE;
          w_done      = 1'b1;
        end else begin
          w_nxt_total = (r_stall_total == '1) ? r_stall_total : r_stall_total + 1'b1;
          if (r_stall_cnt != '0) begin
            w_nxt_cnt = r_stall_cnt - 1'b1;
          end else if (r_addr == r_last) begin
            w_nxt_state = S_HOLD;
          end else begin
            w_nxt_state = S_READ;
            w_nxt_addr  = r_addr + 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (bus.buffer_read_end_i) begin
          w_nxt_state = S_IDLE;
          w_done      = 1'b1;
        end
      end
      default: w_nxt_state = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from values sampled at the same edge.
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      r_state       <= S_IDLE;
      r_addr        <= '0;
      r_last        <= '0;
      r_stall_cnt   <= '0;
      r_stall_total <= '0;
      r_rd_valid    <= 1'b0;
      r_stall       <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_state       <= w_nxt_state;
      r_addr        <= w_nxt_addr;
      r_last        <= w_nxt_last;
      r_stall_cnt   <= w_nxt_cnt;
      r_stall_total <= w_nxt_total;
      r_rd_valid    <= (w_nxt_state == S_READ) || (w_nxt_state == S_STALL);
      r_stall       <= (w_nxt_state == S_STALL);
      r_busy        <= (w_nxt_state != S_IDLE);
      r_done        <= w_done;
    end
  end

  assign bus.addr_o        = r_addr;
  assign bus.rd_valid_o    = r_rd_valid;
  assign bus.stall_o       = r_stall;
  assign bus.busy_o        = r_busy;
  assign bus.done_o        = r_done;
  assign bus.stall_total_o = r_stall_total;

endmodule

// File: tb/tb_msgpass_rqst_addr_gen.sv
// Directed vector bench for msgpass_rqst_addr_gen: a 3-bit-address instance
// (STALL_CYCLES=1) and an 8-bit instance with STALL_CYCLES=2.
module tb_msgpass_rqst_addr_gen;

  logic sys_clk = 1'b0;
  logic rstn    = 1'b0;
  always #5 sys_clk = ~sys_clk;

  msgpass_rqst_addr_gen_if #(.ADDR_WIDTH(3), .DRC_NUM(2), .STAT_WIDTH(16)) if_a ();
  msgpass_rqst_addr_gen_if #(.ADDR_WIDTH(8), .DRC_NUM(2), .STAT_WIDTH(16)) if_b ();

  msgpass_rqst_addr_gen #(.ADDR_WIDTH(3), .DRC_NUM(2), .STALL_CYCLES(1), .STAT_WIDTH(16)) u_a (
    .sys_clk (sys_clk),
    .rstn    (rstn),
    .bus     (if_a)
  );

  msgpass_rqst_addr_gen #(.ADDR_WIDTH(8), .DRC_NUM(2), .STALL_CYCLES(2), .STAT_WIDTH(16)) u_b (
    .sys_clk (sys_clk),
    .rstn    (rstn),
    .bus     (if_b)
  );

  typedef struct {
    string       name;
    bit          inst;     // 0: u_a, 1: u_b
    logic        b, e;
    logic [7:0]  base, last;
    logic [1:0]  drc;
    logic [27:0] exp;      // {addr, rd_valid, stall, busy, done, stall_total}
  } vec_t;

  vec_t vecs[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  task automatic add(input string name, input bit inst, input logic b, input logic e,
                     input logic [7:0] base, input logic [7:0] last, input logic [1:0] drc,
                     input logic [7:0] addr, input logic rv, input logic st,
                     input logic bz, input logic dn, input logic [15:0] tot);
    vec_t v;
    v.name = name; v.inst = inst; v.b = b; v.e = e;
    v.base = base; v.last = last; v.drc = drc;
    v.exp  = {addr, rv, st, bz, dn, tot};
    vecs.push_back(v);
  endtask

  function automatic logic [27:0] pack_a();
    return {5'b0, if_a.addr_o, if_a.rd_valid_o, if_a.stall_o, if_a.busy_o,
            if_a.done_o, if_a.stall_total_o};
  endfunction

  function automatic logic [27:0] pack_b();
    return {if_b.addr_o, if_b.rd_valid_o, if_b.stall_o, if_b.busy_o,
            if_b.done_o, if_b.stall_total_o};
  endfunction

  task automatic check(input string name, input logic [27:0] act, input logic [27:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got addr=%0d rv=%b st=%b busy=%b done=%b tot=%0d, expected addr=%0d rv=%b st=%b busy=%b done=%b tot=%0d",
               name, act[27:20], act[19], act[18], act[17], act[16], act[15:0],
               exp[27:20], exp[19], exp[18], exp[17], exp[16], exp[15:0]);
    end
  endtask

  task automatic drive_idle();
    if_a.buffer_read_begin_i = 1'b0; if_a.buffer_read_end_i = 1'b0;
    if_a.base_addr_i = '0; if_a.last_addr_i = '0; if_a.is_drc_i = '0;
    if_b.buffer_read_begin_i = 1'b0; if_b.buffer_read_end_i = 1'b0;
    if_b.base_addr_i = '0; if_b.last_addr_i = '0; if_b.is_drc_i = '0;
  endtask

  task automatic apply_vec(input vec_t v);
    @(negedge sys_clk);
    drive_idle();
    if (!v.inst) begin
      if_a.buffer_read_begin_i = v.b; if_a.buffer_read_end_i = v.e;
      if_a.base_addr_i = v.base[2:0]; if_a.last_addr_i = v.last[2:0]; if_a.is_drc_i = v.drc;
    end else begin
      if_b.buffer_read_begin_i = v.b; if_b.buffer_read_end_i = v.e;
      if_b.base_addr_i = v.base; if_b.last_addr_i = v.last; if_b.is_drc_i = v.drc;
    end
    @(posedge sys_clk);
    #1;
    check(v.name, v.inst ? pack_b() : pack_a(), v.exp);
  endtask

  initial begin
    vec_t hv;
    drive_idle();

    //   name        inst b  e  base last drc  addr rv st bz dn tot
    // Basic walk 0..4, a begin while busy is ignored, then end after 5 HOLD cycles.
    add("walk_a0",   0, 1, 0, 0, 4, 2'b00, 0, 1, 0, 1, 0, 0);
    add("walk_a1",   0, 0, 0, 0, 0, 2'b00, 1, 1, 0, 1, 0, 0);
    add("busy_beg",  0, 1, 0, 7, 7, 2'b00, 2, 1, 0, 1, 0, 0);
    add("walk_a3",   0, 0, 0, 0, 0, 2'b00, 3, 1, 0, 1, 0, 0);
    add("walk_a4",   0, 0, 0, 0, 0, 2'b00, 4, 1, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++)
      add($sformatf("walk_hold%0d", i), 0, 0, 0, 0, 0, 2'b00, 4, 0, 0, 1, 0, 0);
    add("walk_end",  0, 0, 1, 0, 0, 2'b00, 4, 0, 0, 0, 1, 0);
    add("walk_idle", 0, 0, 0, 0, 0, 2'b00, 4, 0, 0, 0, 0, 0);
    // Single conflict at addr 1: 0,1,1,2; changed flags during STALL are ignored.
    add("drc1_a0",   0, 1, 0, 0, 2, 2'b00, 0, 1, 0, 1, 0, 0);
    add("drc1_a1",   0, 0, 0, 0, 0, 2'b00, 1, 1, 0, 1, 0, 0);
    add("drc1_stl",  0, 0, 0, 0, 0, 2'b01, 1, 1, 1, 1, 0, 0);
    add("drc1_a2",   0, 0, 0, 0, 0, 2'b11, 2, 1, 0, 1, 0, 1);
    add("drc1_hold", 0, 0, 0, 0, 0, 2'b00, 2, 0, 0, 1, 0, 1);
    add("drc1_end",  0, 0, 1, 0, 0, 2'b00, 2, 0, 0, 0, 1, 1);
    // Wrap 6,7,0,1 started with begin and end together (begin wins, total cleared).
    add("wrap_a6",   0, 1, 1, 6, 1, 2'b00, 6, 1, 0, 1, 0, 0);
    add("wrap_a7",   0, 0, 0, 0, 0, 2'b00, 7, 1, 0, 1, 0, 0);
    add("wrap_a0",   0, 0, 0, 0, 0, 2'b00, 0, 1, 0, 1, 0, 0);
    add("wrap_a1",   0, 0, 0, 0, 0, 2'b00, 1, 1, 0, 1, 0, 0);
    add("wrap_hold", 0, 0, 0, 0, 0, 2'b00, 1, 0, 0, 1, 0, 0);
    add("wrap_end",  0, 0, 1, 0, 0, 2'b00, 1, 0, 0, 0, 1, 0);
    // base == last: one READ then HOLD.
    add("one_a3",    0, 1, 0, 3, 3, 2'b00, 3, 1, 0, 1, 0, 0);
    add("one_hold",  0, 0, 0, 0, 0, 2'b00, 3, 0, 0, 1, 0, 0);
    add("one_end",   0, 0, 1, 0, 0, 2'b00, 3, 0, 0, 0, 1, 0);
    // Abort in READ at addr 2.
    add("abt_a0",    0, 1, 0, 0, 5, 2'b00, 0, 1, 0, 1, 0, 0);
    add("abt_a1",    0, 0, 0, 0, 0, 2'b00, 1, 1, 0, 1, 0, 0);
    add("abt_a2",    0, 0, 0, 0, 0, 2'b00, 2, 1, 0, 1, 0, 0);
    add("abt_end",   0, 0, 1, 0, 0, 2'b00, 2, 0, 0, 0, 1, 0);
    add("abt_idle",  0, 0, 0, 0, 0, 2'b00, 2, 0, 0, 0, 0, 0);
    // Two flags on the last address: STALL for 2 cycles, then straight to HOLD.
    add("lst_a4",    0, 1, 0, 4, 5, 2'b00, 4, 1, 0, 1, 0, 0);
    add("lst_a5",    0, 0, 0, 0, 0, 2'b00, 5, 1, 0, 1, 0, 0);
    add("lst_stl0",  0, 0, 0, 0, 0, 2'b11, 5, 1, 1, 1, 0, 0);
    add("lst_stl1",  0, 0, 0, 0, 0, 2'b00, 5, 1, 1, 1, 0, 1);
    add("lst_hold",  0, 0, 0, 0, 0, 2'b00, 5, 0, 0, 1, 0, 2);
    add("lst_end",   0, 0, 1, 0, 0, 2'b00, 5, 0, 0, 0, 1, 2);
    // STALL_CYCLES=2 instance: two flags at addr 0 -> addr 0 held for 5 cycles.
    add("s2_a0",     1, 1, 0, 0, 1, 2'b00, 0, 1, 0, 1, 0, 0);
    add("s2_stl0",   1, 0, 0, 0, 0, 2'b11, 0, 1, 1, 1, 0, 0);
    add("s2_stl1",   1, 0, 0, 0, 0, 2'b01, 0, 1, 1, 1, 0, 1);
    add("s2_stl2",   1, 0, 0, 0, 0, 2'b10, 0, 1, 1, 1, 0, 2);
    add("s2_stl3",   1, 0, 0, 0, 0, 2'b00, 0, 1, 1, 1, 0, 3);
    add("s2_a1",     1, 0, 0, 0, 0, 2'b00, 1, 1, 0, 1, 0, 4);
    add("s2_hold",   1, 0, 0, 0, 0, 2'b00, 1, 0, 0, 1, 0, 4);
    add("s2_end",    1, 0, 1, 0, 0, 2'b00, 1, 0, 0, 0, 1, 4);

    #3;
    check("reset_a", pack_a(), 28'h0);
    check("reset_b", pack_b(), 28'h0);
    @(negedge sys_clk);
    rstn = 1'b1;

    for (int i = 0; i < vecs.size(); i++) apply_vec(vecs[i]);

    // Reset asserted mid-STALL: outputs clear immediately, no done pulse, then a clean restart.
    hv = '{name: "rst_a0", inst: 0, b: 1, e: 0, base: 8'd1, last: 8'd3, drc: 2'b00,
           exp: {8'd1, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0}};
    apply_vec(hv);
    hv = '{name: "rst_stall", inst: 0, b: 0, e: 0, base: 8'd0, last: 8'd0, drc: 2'b11,
           exp: {8'd1, 1'b1, 1'b1, 1'b1, 1'b0, 16'd0}};
    apply_vec(hv);
    #1;
    rstn = 1'b0;
    #1;
    check("rst_async", pack_a(), 28'h0);
    @(negedge sys_clk);
    rstn = 1'b1;
    hv = '{name: "rst_nodone", inst: 0, b: 0, e: 0, base: 8'd0, last: 8'd0, drc: 2'b00,
           exp: 28'h0};
    apply_vec(hv);
    hv = '{name: "rst_restart", inst: 0, b: 1, e: 0, base: 8'd2, last: 8'd3, drc: 2'b00,
           exp: {8'd2, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0}};
    apply_vec(hv);
    hv = '{name: "rst_next", inst: 0, b: 0, e: 0, base: 8'd0, last: 8'd0, drc: 2'b00,
           exp: {8'd3, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0}};
    apply_vec(hv);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
